// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// gouram_mem_pkg
// Shared types and helpers for the data-memory responder.
//   mem_resp_t   : one response beat {err, rdata} carried through the response pipe
//   LFSR_SEED    : reset value of the grant-stall LFSR (only used with GNT_STALL_EN)
//   word_index() : byte address -> word address (addr[1:0] dropped)
//   in_range()   : true when the byte address falls inside the RAM
// MEM_ADDR_W / MEM_DATA_W fix the widths seen by the struct and the helpers;
// the responder's DATA_ADDR_WIDTH / DATA_WIDTH are expected to match them.
// -----------------------------------------------------------------------------
package gouram_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic                  err;
    logic [MEM_DATA_W-1:0] rdata;
  } mem_resp_t;

  // Word address of a byte address; the byte lane bits are ignored.
  function automatic logic [MEM_ADDR_W-1:0] word_index(input logic [MEM_ADDR_W-1:0] addr);
    return addr >> 2;
  endfunction

  // addr < 4*depth_words, written on the word address so that the product
  // cannot overflow for large depths.
  function automatic logic in_range(input logic [MEM_ADDR_W-1:0] addr,
                                    input int unsigned           depth_words);
    return word_index(addr) < depth_words;
  endfunction

endpackage

// File: rtl/data_mem_responder_pipe.sv
// -----------------------------------------------------------------------------
// mem_resp_pipe
// Fixed-latency response pipe: READ_LATENCY register stages of {valid, mem_resp_t}.
// A beat pushed in cycle c appears on o_valid/o_resp in cycle c+READ_LATENCY.
// It also tracks how many responses are in flight so the top can throttle grants.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : a request was accepted this cycle
//   i_resp      : response computed in the accept cycle
//   o_valid     : response beat valid (registered)
//   o_resp      : response beat, holds its last value while o_valid=0
//   o_count     : accepted-but-unanswered requests
//   o_retire    : a response leaves the pipe this cycle
// -----------------------------------------------------------------------------
module mem_resp_pipe
  import gouram_mem_pkg::*;
#(
  parameter  int READ_LATENCY = 2,
  parameter  int OUTSTANDING  = 4,
  localparam int CNT_W        = $clog2(OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  mem_resp_t        i_resp,
  output logic             o_valid,
  output mem_resp_t        o_resp,
  output logic [CNT_W-1:0] o_count,
  output logic             o_retire
);

  logic [READ_LATENCY-1:0] r_vld;
  mem_resp_t               r_resp [READ_LATENCY];
  logic [CNT_W-1:0]        r_count;

  // Data in a stage only moves when a valid beat moves into it, so the last
  // stage keeps the previous response while bubbles pass through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_resp[k] <= '0;
      end
    end else begin
      r_vld[0] <= i_push;
      if (i_push) begin
        r_resp[0] <= i_resp;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_resp[k] <= r_resp[k-1];
        end
      end
    end
  end

  // In-flight counter: +1 on accept, -1 on retire, unchanged when both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({i_push, r_vld[READ_LATENCY-1]})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid  = r_vld[READ_LATENCY-1];
  assign o_resp   = r_resp[READ_LATENCY-1];
  assign o_retire = r_vld[READ_LATENCY-1];
  assign o_count  = r_count;

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Responder end of the core data-memory req/gnt/rvalid interface, backed by a
// word-addressed on-chip RAM with a fixed response latency.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   data_req_i     : request valid (held by the initiator until granted)
//   data_gnt_o     : request accepted this cycle (combinational)
//   data_addr_i    : byte address, addr[1:0] ignored
//   data_we_i      : 1 = write, 0 = read
//   data_be_i      : byte enables for writes
//   data_wdata_i   : write data
//   data_rvalid_o  : one response per accepted request, READ_LATENCY cycles later
//   data_rdata_o   : read data (0 for writes and out-of-range reads)
//   data_err_o     : address was outside the RAM
// Build option: define GNT_STALL_EN to refuse ~25% of grants using a 16-bit
// LFSR; without it grants depend only on request and in-flight count.
// -----------------------------------------------------------------------------
module data_mem_responder
  import gouram_mem_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int READ_LATENCY    = 2,
  parameter int OUTSTANDING     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(OUTSTANDING);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH_WORDS];

  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic             w_stall;
  logic             w_accept;
  logic [CNT_W-1:0] w_count;
  logic             w_retire;
  logic             w_pipe_vld;
  mem_resp_t        w_resp;
  mem_resp_t        w_pipe_resp;

  assign w_idx      = IDX_W'(word_index(data_addr_i));
  assign w_in_range = in_range(data_addr_i, MEM_DEPTH_WORDS);

`ifdef GNT_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11; free-running, reseeded by reset.
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // A full pipe can still take a new request in the cycle a response retires,
  // which keeps back-to-back throughput when OUTSTANDING == READ_LATENCY.
  // rst_n gates the grant so nothing is accepted while reset is held.
  assign w_accept   = rst_n & data_req_i & ~w_stall & ((w_count < OUT_MAX) | w_retire);
  assign data_gnt_o = w_accept;

  // RAM is sampled in the accept cycle; writes land at the end of it, so a
  // write accepted in c-1 is already visible to a read accepted in c.
  always_comb begin
    w_resp       = '0;
    w_resp.err   = ~w_in_range;
    if (!data_we_i && w_in_range) begin
      w_resp.rdata = r_mem[w_idx];
    end
  end

  // RAM contents survive reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (w_accept && data_we_i && w_in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (data_be_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  mem_resp_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .OUTSTANDING  (OUTSTANDING)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_accept),
    .i_resp   (w_resp),
    .o_valid  (w_pipe_vld),
    .o_resp   (w_pipe_resp),
    .o_count  (w_count),
    .o_retire (w_retire)
  );

  assign data_rvalid_o = w_pipe_vld;
  assign data_rdata_o  = w_pipe_resp.rdata;
  assign data_err_o    = w_pipe_resp.err;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int L     = 2;
  localparam int OUTST = 4;
  localparam int DEPTH = 1024;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [3:0]  be    = '0;
  logic [31:0] wdata = '0;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  // second instance: OUTSTANDING=1, READ_LATENCY=3
  logic        req1   = 1'b0;
  logic        we1    = 1'b0;
  logic [31:0] addr1  = '0;
  logic [31:0] wdata1 = '0;
  logic        gnt1, rvalid1, err1;
  logic [31:0] rdata1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_req_i    (req),
    .data_gnt_o    (gnt),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .data_rvalid_o (rvalid),
    .data_rdata_o  (rdata),
    .data_err_o    (err)
  );

  data_mem_responder #(
    .MEM_DEPTH_WORDS (16),
    .READ_LATENCY    (3),
    .OUTSTANDING     (1)
  ) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_req_i    (req1),
    .data_gnt_o    (gnt1),
    .data_addr_i   (addr1),
    .data_we_i     (we1),
    .data_be_i     (4'hF),
    .data_wdata_i  (wdata1),
    .data_rvalid_o (rvalid1),
    .data_rdata_o  (rdata1),
    .data_err_o    (err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
    bit          known;
  } exp_t;

  exp_t        eq[$];
  logic [31:0] mdl[int];
  logic [31:0] h_rdata = '0;
  logic        h_err   = 1'b0;
  bit          h_known = 1'b1;

  always @(negedge clk) begin : model
    exp_t        e;
    bit          due_now, egnt, inr;
    int          idx;
    logic [31:0] w;
    if (!rst_n) begin
      eq.delete();
      h_rdata = '0;
      h_err   = 1'b0;
      h_known = 1'b1;
      chk("rst_gnt",    gnt,    0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata",  rdata,  0);
      chk("rst_err",    err,    0);
    end else begin
      due_now = (eq.size() > 0) && (eq[0].due == cyc);
      egnt    = req && ((eq.size() < OUTST) || due_now);
      chk("gnt",    gnt,    egnt);
      chk("rvalid", rvalid, due_now);
      if (due_now) begin
        e       = eq.pop_front();
        h_rdata = e.rdata;
        h_err   = e.err;
        h_known = e.known;
      end
      if (h_known) chk("rdata", rdata, h_rdata);
      chk("err", err, h_err);
      if (egnt) begin
        idx     = int'(addr / 4);
        inr     = (addr / 4) < DEPTH;
        e.due   = cyc + L;
        e.err   = !inr;
        e.rdata = '0;
        e.known = 1'b1;
        if (we) begin
          if (inr && (mdl.exists(idx) || be == 4'hF)) begin
            w = mdl.exists(idx) ? mdl[idx] : '0;
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            mdl[idx] = w;
          end
        end else if (inr) begin
          if (mdl.exists(idx)) e.rdata = mdl[idx];
          else e.known = 1'b0;
        end
        eq.push_back(e);
      end
    end
  end

  // record every response of the main instance for directed checks
  exp_t rv_q[$];
  always @(negedge clk) begin
    exp_t r;
    if (rst_n && rvalid) begin
      r.due = cyc; r.rdata = rdata; r.err = err; r.known = 1'b1;
      rv_q.push_back(r);
    end
  end

  // caller is at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output int acc);
    req = 1'b1; we = w; addr = a; be = b; wdata = d; acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt) begin
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) fail_now("issue_timeout");
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output exp_t r);
    r = '{due: -1, rdata: '0, err: 1'b0, known: 1'b0};
    for (int i = 0; i < 50; i++) begin
      if (rv_q.size() > 0) break;
      @(negedge clk); #1;
    end
    if (rv_q.size() > 0) r = rv_q.pop_front();
    else fail_now("resp_timeout");
  endtask

  initial begin
    int   a0, a1;
    int   acc[10];
    exp_t r;
    bit   last_gnt;

    // reset with a request pending: no grant, outputs cleared
    #1 rst_n = 1'b0; req = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; req = 1'b0;
    idle(2);

    // known contents for words 0..15
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i), a0);
    idle(4);
    rv_q.delete();

    // 10 back-to-back reads
    for (int i = 0; i < 10; i++) issue(1'b0, 32'(i * 4), 4'h0, '0, acc[i]);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) chk("b2b_gnt_consecutive", acc[i], acc[i-1] + 1);
      wait_resp(r);
      chk("b2b_latency", r.due, acc[i] + 2);
      chk("b2b_rdata", r.rdata, 32'hC0DE0000 + 32'(i));
    end
    idle(2);

    // write DEADBEEF then read it back
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, a0);
    issue(1'b0, 32'h10, 4'h0, '0, a1);
    idle(1);
    wait_resp(r);
    chk("wr_latency", r.due, a0 + 2);
    chk("wr_rdata", r.rdata, 32'h0);
    chk("wr_err", r.err, 0);
    wait_resp(r);
    chk("rd_latency", r.due, a1 + 2);
    chk("rd_rdata", r.rdata, 32'hDEADBEEF);
    chk("rd_err", r.err, 0);
    idle(2);

    // byte-enable merge
    issue(1'b1, 32'h20, 4'hF,    32'h11223344, a0);
    issue(1'b1, 32'h20, 4'b0010, 32'h0000AB00, a0);
    issue(1'b0, 32'h20, 4'h0,    '0, a1);
    idle(1);
    wait_resp(r);
    wait_resp(r);
    wait_resp(r);
    chk("be_rdata", r.rdata, 32'h1122AB44);
    idle(2);

    // out of range read and write
    issue(1'b0, 32'h1000, 4'h0, '0, a1);
    idle(1);
    wait_resp(r);
    chk("oor_latency", r.due, a1 + 2);
    chk("oor_rdata", r.rdata, 32'h0);
    chk("oor_err", r.err, 1);
    idle(1);
    issue(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, a0);
    issue(1'b0, 32'h0,    4'h0, '0, a1);
    idle(1);
    wait_resp(r);
    chk("oor_wr_err", r.err, 1);
    wait_resp(r);
    chk("word0_rdata", r.rdata, 32'hC0DE0000);
    chk("word0_err", r.err, 0);
    idle(2);

    // reset one cycle after accepting two reads
    rv_q.delete();
    issue(1'b0, 32'h4, 4'h0, '0, a0);
    issue(1'b0, 32'h8, 4'h0, '0, a1);
    rst_n = 1'b0; req = 1'b1;
    @(negedge clk);
    chk("rst_mid_gnt", gnt, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    chk("rst_no_rvalid", rv_q.size(), 0);
    issue(1'b0, 32'h10, 4'h0, '0, a0);
    idle(1);
    wait_resp(r);
    chk("post_rst_latency", r.due, a0 + 2);
    chk("post_rst_rdata", r.rdata, 32'hDEADBEEF);
    idle(2);

    // OUTSTANDING=1, READ_LATENCY=3: write then held reads
    req1 = 1'b1; we1 = 1'b1; addr1 = '0; wdata1 = 32'h5A5A1234;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("d1_gnt", gnt1, (k % 3 == 0));
      chk("d1_rvalid", rvalid1, (k % 3 == 0 && k > 0));
      if (k == 3) begin
        chk("d1_wr_rdata", rdata1, 32'h0);
        chk("d1_wr_err", err1, 0);
      end
      if (k == 6) chk("d1_rd_rdata", rdata1, 32'h5A5A1234);
      @(posedge clk); #1;
      we1 = 1'b0;
    end
    req1 = 1'b0;
    idle(4);

    // randomized traffic, model-checked every cycle
    last_gnt = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if (!req || last_gnt) begin
        req   = ($urandom_range(0, 9) < 7);
        we    = 1'($urandom_range(0, 1));
        be    = 4'($urandom);
        wdata = $urandom;
        case ($urandom_range(0, 9))
          0:       addr = 32'h1000 + 32'($urandom_range(0, 255));
          1:       addr = $urandom;
          default: addr = 32'($urandom_range(0, 63));
        endcase
      end
      @(negedge clk);
      last_gnt = gnt;
      @(posedge clk); #1;
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
